// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
// Holds the FSM encoding, bus widths and the BUSY timeout default.
package pipe_ctrl_pkg;

    localparam int ADDR_W           = 32;
    localparam int REG_W            = 5;
    localparam int BUSY_TIMEOUT_DEF = 64;
    localparam int STALL_CNT_W_DEF  = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Timeout counter only has to reach BUSY_TIMEOUT-1.
    function automatic int tmo_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline <-> controller signal bundle: hazard inputs from the pipeline
// stages and the hold/flush/redirect controls going back to them.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = STALL_CNT_W_DEF
);
    logic              jump_en_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              ex_is_load_i;
    logic [REG_W-1:0]  ex_rd_addr_i;
    logic              id_rs1_ren_i;
    logic [REG_W-1:0]  id_rs1_addr_i;
    logic              id_rs2_ren_i;
    logic [REG_W-1:0]  id_rs2_addr_i;
    logic              div_start_i;
    logic              div_done_i;
    logic              bus_hold_i;

    logic              hold_pc_o;
    logic              hold_if_id_o;
    logic              hold_id_ex_o;
    logic              flush_if_id_o;
    logic              flush_id_ex_o;
    logic              jump_en_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              busy_o;
    logic              timeout_err_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output jump_en_i, jump_addr_i, ex_is_load_i, ex_rd_addr_i,
               id_rs1_ren_i, id_rs1_addr_i, id_rs2_ren_i, id_rs2_addr_i,
               div_start_i, div_done_i, bus_hold_i,
        input  hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
               jump_en_o, jump_addr_o, busy_o, timeout_err_o, stall_cnt_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, ex_is_load_i, ex_rd_addr_i,
               id_rs1_ren_i, id_rs1_addr_i, id_rs2_ren_i, id_rs2_addr_i,
               div_start_i, div_done_i, bus_hold_i,
        output hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
               jump_en_o, jump_addr_o, busy_o, timeout_err_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_det.sv
// Load-use detector: a load in EX writing a register that ID is about to read.
// x0 is hard-wired zero, so it never creates a dependency.
module pipe_hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd_addr,
    input  logic             rs1_ren,
    input  logic [REG_W-1:0] rs1_addr,
    input  logic             rs2_ren,
    input  logic [REG_W-1:0] rs2_addr,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = rs1_ren && (rs1_addr == ex_rd_addr);
    assign rs2_hit  = rs2_ren && (rs2_addr == ex_rd_addr);
    assign load_use = ex_is_load && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush/redirect controller with a BUSY state for multi-cycle EX ops.
// state   | meaning
// ST_RUN  | normal issue; jumps, div start and load-use bubbles handled here
// ST_BUSY | multi-cycle op in EX; front end held until done or timeout
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    parameter int CNT_W        = STALL_CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave ctrl
);

    localparam int              TMO_W    = tmo_width(BUSY_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              timeout_err;
    logic [CNT_W-1:0]  stall_cnt;

    logic              load_use;
    logic              hold_pc;
    logic              hold_if_id;
    logic              hold_id_ex;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              pend_set;
    logic              pend_clr;
    logic              tmo_hit;

    pipe_hazard_det u_hazard (
        .ex_is_load (ctrl.ex_is_load_i),
        .ex_rd_addr (ctrl.ex_rd_addr_i),
        .rs1_ren    (ctrl.id_rs1_ren_i),
        .rs1_addr   (ctrl.id_rs1_addr_i),
        .rs2_ren    (ctrl.id_rs2_ren_i),
        .rs2_addr   (ctrl.id_rs2_addr_i),
        .load_use   (load_use)
    );

    always_comb begin
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = '0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        tmo_hit     = 1'b0;
        state_nxt   = state;

        if (ctrl.bus_hold_i) begin
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
            hold_id_ex = 1'b1;
            pend_set   = ctrl.jump_en_i && !pend_vld;
        end else if (state == ST_BUSY) begin
            hold_pc    = !ctrl.div_done_i;
            hold_if_id = !ctrl.div_done_i;
            hold_id_ex = !ctrl.div_done_i;
        end else if (pend_vld || ctrl.jump_en_i) begin
            jump_en     = 1'b1;
            jump_addr   = pend_vld ? pend_addr : ctrl.jump_addr_i;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pend_clr    = 1'b1;
        end else if (ctrl.div_start_i) begin
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
            hold_id_ex = 1'b1;
            state_nxt  = ST_BUSY;
        end else if (load_use) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
        end

        // BUSY exit does not depend on bus_hold_i; the holds above cover that case.
        if (state == ST_BUSY) begin
            if (ctrl.div_done_i) begin
                state_nxt = ST_RUN;
            end else if (tmo_cnt == TMO_LAST) begin
                state_nxt = ST_RUN;
                tmo_hit   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pend_vld    <= 1'b0;
            pend_addr   <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (state == ST_RUN && state_nxt == ST_BUSY) begin
                tmo_cnt <= '0;
            end else if (state == ST_BUSY) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (pend_set) begin
                pend_vld  <= 1'b1;
                pend_addr <= ctrl.jump_addr_i;
            end else if (pend_clr) begin
                pend_vld <= 1'b0;
            end

            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end

            if (hold_pc && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Controls are combinational from inputs, so force them quiet while in reset.
    assign ctrl.hold_pc_o     = rst_n & hold_pc;
    assign ctrl.hold_if_id_o  = rst_n & hold_if_id;
    assign ctrl.hold_id_ex_o  = rst_n & hold_id_ex;
    assign ctrl.flush_if_id_o = rst_n & flush_if_id;
    assign ctrl.flush_id_ex_o = rst_n & flush_id_ex;
    assign ctrl.jump_en_o     = rst_n & jump_en;
    assign ctrl.jump_addr_o   = rst_n ? jump_addr : '0;
    assign ctrl.busy_o        = (state == ST_BUSY);
    assign ctrl.timeout_err_o = timeout_err;
    assign ctrl.stall_cnt_o   = stall_cnt;

endmodule
